// File: rtl/xor_arbiter.sv
// Round-robin arbiter sharing one XOR gate among NREQ requesters, with a tagged response channel.
// Optional served-transaction counter enabled by defining XOR_ARB_STATS_EN.

module XOR #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z
);
  assign z = a ^ b;
endmodule

// state  | meaning
// S_IDLE | searching for a requester from ptr onward; grant accepted same cycle
// S_RESP | result of registered operands presented until consumer takes it
module xor_arbiter #(
  parameter int  WIDTH = 5,
  parameter int  NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_z,
  output logic [IDW-1:0]        resp_id
`ifdef XOR_ARB_STATS_EN
  ,
  output logic [15:0]           served_cnt
`endif
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]   grant;
  logic             grant_vld;
  logic             accept;
  logic             resp_hs;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && grant_vld && !rst;
  assign resp_hs = (state_q == S_RESP) && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RESP;
          id_d    = grant;
          op_a_d  = req_a[int'(grant)*WIDTH +: WIDTH];
          op_b_d  = req_b[int'(grant)*WIDTH +: WIDTH];
          ptr_d   = (int'(grant) == NREQ-1) ? '0 : grant + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    if (accept) req_ready[grant] = 1'b1;
    if (state_q == S_RESP) resp_valid = 1'b1;
  end

  // Only path to resp_z is through the registered operands.
  XOR #(.WIDTH(WIDTH)) u_xor (
    .a (op_a_q),
    .b (op_b_q),
    .z (resp_z)
  );

  assign resp_id = id_q;

`ifdef XOR_ARB_STATS_EN
  logic [15:0] served_q, served_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) served_q <= '0;
    else     served_q <= served_d;
  end

  always_comb begin
    served_d = served_q;
    if (resp_hs) served_d = served_q + 16'd1;
  end

  assign served_cnt = served_q;
`endif

endmodule

// File: tb/tb_xor_arbiter.sv
// Scoreboard bench for xor_arbiter: stimulus pushes expected {id,z}, a monitor pops on each response handshake.
module tb_xor_arbiter;
  localparam int WIDTH = 5;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_z;
  logic [IDW-1:0]        resp_id;
`ifdef XOR_ARB_STATS_EN
  logic [15:0]           served_cnt;
`endif

  xor_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_z     (resp_z),
    .resp_id    (resp_id)
`ifdef XOR_ARB_STATS_EN
    ,
    .served_cnt (served_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [IDW+WIDTH-1:0] exp_q[$];
  logic [IDW+WIDTH-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL resp_unexpected: got id=%0d z=%0h expected no response", resp_id, resp_z);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_id", 32'(resp_id), 32'(mon_e[IDW+WIDTH-1:WIDTH]));
        chk("resp_z", 32'(resp_z), 32'(mon_e[WIDTH-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Each grant in a lockstep sequence: accept cycle, then handshake cycle.
  task automatic run_seq(input int n, input logic [1:0] ids[5], input logic [4:0] zs[5]);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({ids[k], zs[k]});
      @(negedge clk);
      chk("grant_ready", 32'(req_ready), 32'(4'b0001 << ids[k]));
      tick();
      if (k == n-1) req_valid = '0;
      @(negedge clk);
      chk("resp_cycle_ready", 32'(req_ready), 32'd0);
      chk("resp_cycle_valid", 32'(resp_valid), 32'd1);
      tick();
    end
  endtask

  logic [1:0] ids_c[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [4:0] zs_c[5]  = '{5'h1F, 5'h1E, 5'h1D, 5'h1C, 5'h1F};
  logic [1:0] ids_f[5] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd0};
  logic [4:0] zs_f[5]  = '{5'h06, 5'h1D, 5'h06, 5'h00, 5'h00};

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_z", 32'(resp_z), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // single request
    set_op(0, 5'h0F, 5'h13);
    req_valid = 4'b0001;
    exp_q.push_back({2'd0, 5'h1C});
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_z", 32'(resp_z), 32'h1C);
    chk("single_id", 32'(resp_id), 32'd0);
    tick();
    resp_ready = 1'b0;

    // contention from ptr=0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 5'(i), 5'h1F);
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    run_seq(5, ids_c, zs_c);
    resp_ready = 1'b0;

    // backpressure, ptr=1 -> grant 2
    set_op(2, 5'h0A, 5'h05);
    req_valid = 4'b0100;
    exp_q.push_back({2'd2, 5'h0F});
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      set_op(2, 5'(c + 7), 5'(c * 3));
      set_op(0, 5'(c), 5'h11);
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_z_hold", 32'(resp_z), 32'h0F);
      chk("bp_id_hold", 32'(resp_id), 32'd2);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hs_no_accept", 32'(req_ready), 32'd0);
    tick();
    req_valid  = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_done", 32'(resp_valid), 32'd0);
    tick();

    // reset mid-RESP, ptr=3 -> grant 2
    set_op(2, 5'h01, 5'h02);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("mid_valid", 32'(resp_valid), 32'd1);
    chk("mid_id", 32'(resp_id), 32'd2);
    #2;
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("async_valid_drop", 32'(resp_valid), 32'd0);
    chk("async_z", 32'(resp_z), 32'd0);
    chk("async_id", 32'(resp_id), 32'd0);
    chk("rst_ready_forced", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 5'(i), 5'h1F);
    resp_ready = 1'b1;
    run_seq(1, ids_c, zs_c);
    resp_ready = 1'b0;

    // fairness skip
    do_reset();
    set_op(1, 5'h03, 5'h05);
    set_op(3, 5'h11, 5'h0C);
    req_valid  = 4'b1010;
    resp_ready = 1'b1;
    run_seq(3, ids_f, zs_f);
    resp_ready = 1'b0;

    // ten transactions from reset
    do_reset();
    resp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_op(0, 5'(k), 5'h15);
      req_valid = 4'b0001;
      exp_q.push_back({2'd0, 5'(k) ^ 5'h15});
      @(negedge clk);
      chk("ten_grant", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      @(negedge clk);
      tick();
    end
`ifdef XOR_ARB_STATS_EN
    @(negedge clk);
    chk("served_cnt", 32'(served_cnt), 32'd10);
`endif
    resp_ready = 1'b0;
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xor_arbiter.md
# xor_arbiter

Round-robin arbiter and sequencer that shares one `XOR` gate instance between `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time and registers the operands into the shared `XOR` datapath. It then returns the result on a single response channel, tagged with the requester index. It sits between multiple operand producers and the gate library's `XOR` primitive, which it instantiates internally.

## Interface
Parameters:
- `WIDTH`, 5: operand/result width; passed to the internal `XOR` instance.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW` (localparam), `$clog2(NREQ)`: requester index width.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req_valid`  input  NREQ  bit i: requester i presents operands.
- `req_ready`  output  NREQ  bit i: requester i accepted this cycle; at most one bit high.
- `req_a`  input  NREQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH].
- `req_b`  input  NREQ*WIDTH  operand b, same packing.
- `resp_valid`  output  1  result available.
- `resp_ready`  input  1  consumer accepts result.
- `resp_z`  output  WIDTH  a XOR b of the granted request.
- `resp_id`  output  IDW  index of the requester that produced `resp_z`.
- `served_cnt`  output  16  completed-transaction count; present only with `XOR_ARB_STATS_EN`.

## Operation
- FSM has two states: IDLE and RESP.
- IDLE:
  - Grant g is the first i with `req_valid[i]=1`, searching `ptr`, `ptr+1`, … mod NREQ.
  - `req_ready[g]=1` combinationally, same cycle. All other bits are 0. If no valid, all are 0.
  - On accept, register `req_a[g]` and `req_b[g]` into `op_a`/`op_b` and register `id<=g`.
  - On accept, set `ptr <= (g+1) mod NREQ` and go to RESP.
- RESP:
  - `resp_valid=1`. `resp_z` is the shared `XOR` output on `op_a`/`op_b`. `resp_id=id`.
  - `req_ready` is all 0.
  - On `resp_valid && resp_ready`, go to IDLE. No new request is accepted in that same cycle.
- `resp_z`, `resp_id` are held stable for the whole RESP state regardless of `resp_ready` or input changes.
- Requester inputs are sampled only in the accept cycle. Later changes do not affect the result.
- Arbiter never drops `req_valid`-side data: a non-granted requester simply sees `req_ready=0` and must hold.
- `ptr` wraps from NREQ-1 to 0.
- Exactly one `XOR` instance exists; no combinational path from `req_*` to `resp_z`.

## Timing
- Reset values:
  - state=IDLE, `ptr=0`, `op_a=op_b=0`, `id=0`.
  - `resp_valid=0`, `resp_z=0`, `resp_id=0`, `req_ready=0`.
  - `served_cnt=0` (when enabled).
- `req_ready` is forced to 0 while `rst` is high.
- Latency: accept at edge N, then `resp_valid=1` in the cycle after edge N.
- Throughput is at most one transaction per 2 cycles, with `resp_ready` held high.
- Reset mid-RESP: the pending response is discarded, `resp_valid` drops asynchronously, and `ptr` returns to 0.
- Simultaneous requests: exactly one grant, per the round-robin order above.
- Single persistent requester: granted every IDLE cycle; `ptr` leaves then returns to it.

## Configuration
- `XOR_ARB_STATS_EN` defined:
  - Adds output `served_cnt[15:0]`.
  - It increments on each `resp_valid && resp_ready` handshake and wraps 16'hFFFF to 0.
  - It resets to 0.
- `XOR_ARB_STATS_EN` undefined: port and counter are absent; behaviour is otherwise identical.

## Test plan
Bench uses WIDTH=5, NREQ=4, 10 ns clock.
- Single request: `req_valid=4'b0001`, a0=5'h0F, b0=5'h13 → `req_ready=4'b0001` same cycle; next cycle `resp_valid=1`, `resp_z=5'h1C`, `resp_id=0`.
- Contention: all four valid after reset, `resp_ready=1`, operands a_i=i, b_i=5'h1F → grants in order 0,1,2,3,0. `resp_z` sequence is 1F,1E,1D,1C,1F. Accepts land every 2 cycles.
- Backpressure: `resp_ready=0` for 3 cycles in RESP, operands changed meanwhile → `resp_z`/`resp_id` unchanged and `req_ready=0` throughout. Handshake completes on the cycle `resp_ready` rises.
- Reset mid-operation: assert `rst` during RESP (id=2) → `resp_valid=0` immediately. After release, with all valid, the first grant is requester 0.
- Fairness skip: `req_valid=4'b1010` with `ptr=0` → grant 1, then grant 3, then grant 1.
- `XOR_ARB_STATS_EN` defined: 10 completed transactions → `served_cnt=10`. Undefined build compiles without the port.
